// File: rtl/button_event_unit.sv
// Button synchronizer, per-bit debouncer and sticky press/release event registers on the ulisp register bus.
// Optional macro BUTTON_RELEASE_EVENT_EN adds release flags and the RELEASE register at BASE_INDEX+2.
module button_event_unit #(
  parameter int unsigned NUM_BUTTONS     = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned BASE_INDEX      = 6,
  parameter int unsigned ACTIVE_LOW      = 0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_BUTTONS-1:0] buttons,
  input  logic [6:0]             register_index,
  input  logic                   register_read,
  input  logic                   register_write,
  input  logic [15:0]            register_write_value,
  output logic [15:0]            register_read_value,
  output logic                   event_pending,
  output logic [NUM_BUTTONS-1:0] buttons_stable
);

  localparam int unsigned    CNT_W       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [6:0]     IDX_STATE   = 7'(BASE_INDEX);
  localparam logic [6:0]     IDX_PRESS   = 7'(BASE_INDEX + 1);

  logic [NUM_BUTTONS-1:0]            buttons_in;
  logic [NUM_BUTTONS-1:0]            sync0;
  logic [NUM_BUTTONS-1:0]            sync1;
  logic [NUM_BUTTONS-1:0][CNT_W-1:0] cnt_q;
  logic [NUM_BUTTONS-1:0][CNT_W-1:0] cnt_d;
  logic [NUM_BUTTONS-1:0]            stable_d;
  logic [NUM_BUTTONS-1:0]            press_flags;
  logic [NUM_BUTTONS-1:0]            press_d;
  logic [NUM_BUTTONS-1:0]            press_clr;
  logic [NUM_BUTTONS-1:0]            wr_mask;
  logic [15:0]                       rdata_d;
  logic                              hit_state;
  logic                              hit_press;
  logic                              unused_wdata;

  assign buttons_in   = (ACTIVE_LOW != 0) ? ~buttons : buttons;
  assign hit_state    = (register_index == IDX_STATE);
  assign hit_press    = (register_index == IDX_PRESS);
  assign wr_mask      = register_write_value[NUM_BUTTONS-1:0];
  assign unused_wdata = ^register_write_value;

  // Debounce: a new level is accepted only after DEBOUNCE_CYCLES consecutive differing samples
  always_comb begin
    stable_d = buttons_stable;
    cnt_d    = '0;
    for (int i = 0; i < int'(NUM_BUTTONS); i++) begin
      if (sync1[i] != buttons_stable[i]) begin
        if (cnt_q[i] == CNT_LAST) stable_d[i] = sync1[i];
        else                      cnt_d[i]    = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Set has priority over read-clear and write-1-to-clear on the same edge
  always_comb begin
    press_clr = ({NUM_BUTTONS{register_read  & hit_press}})
              | ({NUM_BUTTONS{register_write & hit_press}} & wr_mask);
    press_d   = (press_flags & ~press_clr) | (stable_d & ~buttons_stable);
  end

`ifdef BUTTON_RELEASE_EVENT_EN
  localparam logic [6:0] IDX_RELEASE = 7'(BASE_INDEX + 2);

  logic                   hit_release;
  logic [NUM_BUTTONS-1:0] release_flags;
  logic [NUM_BUTTONS-1:0] release_d;
  logic [NUM_BUTTONS-1:0] release_clr;

  assign hit_release = (register_index == IDX_RELEASE);

  always_comb begin
    release_clr = ({NUM_BUTTONS{register_read  & hit_release}})
                | ({NUM_BUTTONS{register_write & hit_release}} & wr_mask);
    release_d   = (release_flags & ~release_clr) | (~stable_d & buttons_stable);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) release_flags <= '0;
    else          release_flags <= release_d;
  end

  assign event_pending = (|press_flags) | (|release_flags);
`else
  assign event_pending = |press_flags;
`endif

  // Read data holds between reads; an unmatched read returns zero so the top can OR blocks together
  always_comb begin
    rdata_d = register_read_value;
    if (register_read) begin
      rdata_d = '0;
      if (hit_state) rdata_d = 16'(buttons_stable);
      if (hit_press) rdata_d = 16'(press_flags);
`ifdef BUTTON_RELEASE_EVENT_EN
      if (hit_release) rdata_d = 16'(release_flags);
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync0               <= '0;
      sync1               <= '0;
      cnt_q               <= '0;
      buttons_stable      <= '0;
      press_flags         <= '0;
      register_read_value <= '0;
    end else begin
      sync0               <= buttons_in;
      sync1               <= sync0;
      cnt_q               <= cnt_d;
      buttons_stable      <= stable_d;
      press_flags         <= press_d;
      register_read_value <= rdata_d;
    end
  end

endmodule

// File: tb/tb_button_event_unit.sv
// Scoreboarded bench for button_event_unit with DEBOUNCE_CYCLES=4 (pin-to-stable latency of 6 edges).
module tb_button_event_unit;

  localparam int unsigned NB = 4;
  localparam int unsigned LAT = 6;

`ifdef BUTTON_RELEASE_EVENT_EN
  localparam bit REL_EN = 1'b1;
`else
  localparam bit REL_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [NB-1:0] buttons = '0;
  logic [6:0]    register_index = '0;
  logic          register_read = 1'b0;
  logic          register_write = 1'b0;
  logic [15:0]   register_write_value = '0;
  logic [15:0]   register_read_value;
  logic          event_pending;
  logic [NB-1:0] buttons_stable;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] sb[$];
  logic [15:0] exp_rd;

  always #5 clk = ~clk;

  button_event_unit #(
    .NUM_BUTTONS(NB), .DEBOUNCE_CYCLES(4), .BASE_INDEX(6), .ACTIVE_LOW(0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .buttons(buttons),
    .register_index(register_index), .register_read(register_read),
    .register_write(register_write), .register_write_value(register_write_value),
    .register_read_value(register_read_value), .event_pending(event_pending),
    .buttons_stable(buttons_stable)
  );

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one read strobe and record what the bus must return on the following edge
  task automatic bus_read(input logic [6:0] idx, input logic [15:0] exp);
    register_index = idx;
    register_read  = 1'b1;
    sb.push_back(exp);
    tick();
    register_read  = 1'b0;
  endtask

  task automatic bus_write(input logic [6:0] idx, input logic [15:0] val);
    register_index       = idx;
    register_write       = 1'b1;
    register_write_value = val;
    tick();
    register_write       = 1'b0;
    register_write_value = '0;
  endtask

  task automatic test_reset;
    buttons = 4'b1111;
    tick(3);
    n_checks++;
    if (buttons_stable !== 4'b0000 || register_read_value !== 16'h0 || event_pending !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: stable=%b rd=%h ev=%b required 0000/0000/0", buttons_stable, register_read_value, event_pending);
    end
    reset_n = 1'b1;
    for (int e = 1; e <= int'(LAT); e++) begin
      tick();
      n_checks++;
      if (buttons_stable !== ((e == int'(LAT)) ? 4'b1111 : 4'b0000)) begin
        n_fail++;
        $display("FAIL reset_latency edge %0d: stable=%b", e, buttons_stable);
      end
    end
    n_checks++;
    if (event_pending !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_event_pending: got %b required 1", event_pending);
    end
    bus_read(7'd7, 16'h000F);
    exp_rd = sb.pop_front();
    n_checks++;
    if (register_read_value !== exp_rd) begin
      n_fail++;
      $display("FAIL reset_press_read: got %h required %h", register_read_value, exp_rd);
    end
    buttons = 4'b0000;
    tick(LAT);
    bus_read(7'd8, REL_EN ? 16'h000F : 16'h0000);
    exp_rd = sb.pop_front();
    n_checks++;
    if (register_read_value !== exp_rd || event_pending !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_read: got %h ev=%b required %h ev=0", register_read_value, event_pending, exp_rd);
    end
  endtask

  task automatic test_glitch;
    buttons = 4'b0001;
    tick(2);
    buttons = 4'b0000;
    tick();
    buttons = 4'b0001;
    tick(LAT - 1);
    n_checks++;
    if (buttons_stable !== 4'b0000) begin
      n_fail++;
      $display("FAIL glitch_early: stable=%b required 0000", buttons_stable);
    end
    tick();
    n_checks++;
    if (buttons_stable !== 4'b0001 || event_pending !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch_accept: stable=%b ev=%b required 0001/1", buttons_stable, event_pending);
    end
    bus_read(7'd7, 16'h0001);
    exp_rd = sb.pop_front();
    n_checks++;
    if (register_read_value !== exp_rd) begin
      n_fail++;
      $display("FAIL glitch_press_read: got %h required %h", register_read_value, exp_rd);
    end
  endtask

  task automatic test_read_clear;
    buttons = 4'b0101;
    tick(LAT);
    bus_read(7'd7, 16'h0004);
    exp_rd = sb.pop_front();
    n_checks++;
    if (register_read_value !== exp_rd || event_pending !== 1'b0) begin
      n_fail++;
      $display("FAIL rc_first_read: got %h ev=%b required %h ev=0", register_read_value, event_pending, exp_rd);
    end
    bus_read(7'd7, 16'h0000);
    exp_rd = sb.pop_front();
    n_checks++;
    if (register_read_value !== exp_rd) begin
      n_fail++;
      $display("FAIL rc_second_read: got %h required %h", register_read_value, exp_rd);
    end
    bus_read(7'd6, 16'h0005);
    exp_rd = sb.pop_front();
    n_checks++;
    if (register_read_value !== exp_rd) begin
      n_fail++;
      $display("FAIL rc_state_read: got %h required %h", register_read_value, exp_rd);
    end
  endtask

  task automatic test_w1c;
    buttons = 4'b0000;
    tick(LAT);
    buttons = 4'b0011;
    tick(LAT);
    bus_write(7'd7, 16'h0001);
    bus_write(7'd6, 16'hFFFF);
    n_checks++;
    if (event_pending !== 1'b1) begin
      n_fail++;
      $display("FAIL w1c_pending: got %b required 1", event_pending);
    end
    bus_read(7'd6, 16'h0003);
    exp_rd = sb.pop_front();
    n_checks++;
    if (register_read_value !== exp_rd) begin
      n_fail++;
      $display("FAIL w1c_state_read: got %h required %h", register_read_value, exp_rd);
    end
    bus_read(7'd5, 16'h0000);
    exp_rd = sb.pop_front();
    n_checks++;
    if (register_read_value !== exp_rd) begin
      n_fail++;
      $display("FAIL w1c_nomatch_read: got %h required %h", register_read_value, exp_rd);
    end
    bus_read(7'd7, 16'h0002);
    exp_rd = sb.pop_front();
    n_checks++;
    if (register_read_value !== exp_rd) begin
      n_fail++;
      $display("FAIL w1c_press_read: got %h required %h", register_read_value, exp_rd);
    end
  endtask

  task automatic test_set_clear_collision;
    buttons = 4'b0001;
    tick(LAT);
    buttons = 4'b0011;
    tick(LAT - 1);
    bus_read(7'd7, 16'h0000);
    exp_rd = sb.pop_front();
    n_checks++;
    if (register_read_value !== exp_rd || buttons_stable !== 4'b0011 || event_pending !== 1'b1) begin
      n_fail++;
      $display("FAIL collide_read: got %h stable=%b ev=%b required %h/0011/1", register_read_value, buttons_stable, event_pending, exp_rd);
    end
    bus_read(7'd7, 16'h0002);
    exp_rd = sb.pop_front();
    n_checks++;
    if (register_read_value !== exp_rd) begin
      n_fail++;
      $display("FAIL collide_flag_kept: got %h required %h", register_read_value, exp_rd);
    end
  endtask

  task automatic test_release;
    bus_read(7'd8, REL_EN ? 16'h0007 : 16'h0000);
    exp_rd = sb.pop_front();
    n_checks++;
    if (register_read_value !== exp_rd) begin
      n_fail++;
      $display("FAIL rel_prior_read: got %h required %h", register_read_value, exp_rd);
    end
    buttons = 4'b1011;
    tick(LAT);
    buttons = 4'b0011;
    tick(LAT);
    bus_read(7'd7, 16'h0008);
    exp_rd = sb.pop_front();
    n_checks++;
    if (register_read_value !== exp_rd || event_pending !== REL_EN) begin
      n_fail++;
      $display("FAIL rel_press_read: got %h ev=%b required %h ev=%b", register_read_value, event_pending, exp_rd, REL_EN);
    end
    bus_read(7'd8, REL_EN ? 16'h0008 : 16'h0000);
    exp_rd = sb.pop_front();
    n_checks++;
    if (register_read_value !== exp_rd || event_pending !== 1'b0) begin
      n_fail++;
      $display("FAIL rel_release_read: got %h ev=%b required %h ev=0", register_read_value, event_pending, exp_rd);
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_read_clear();
    test_w1c();
    test_set_clear_collision();
    test_release();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
